uart_tx_rv32: RTL
=================

UART_TX_RV32 -- requirements
Module: uart_tx_rv32

Interface
REQ-001 SHALL have parameter CLKDIV, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have port iCLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iWR  input  1  core store strobe to the TX data register, one byte per cycle high.
REQ-006 SHALL have port iWDATA  input  8  byte to transmit, sampled when iWR high.
REQ-007 SHALL have port oFULL  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port oBUSY  output  1  FIFO non-empty or frame in progress.
REQ-009 SHALL have port oLEVEL  output  5  current FIFO occupancy, 0..DEPTH.
REQ-010 SHALL have port oUART_TX  output  1  serial line, idle high.

Function
REQ-011 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-012 SHALL hold every bit on oUART_TX for exactly CLKDIV cycles, using a baud counter reloaded at each bit boundary; frame length exactly 10*CLKDIV cycles.
REQ-013 SHALL push iWDATA into the FIFO at a rising edge where iWR=1 and oFULL=0; writes with oFULL=1 are silently dropped, FIFO contents unchanged.
REQ-014 SHALL evaluate oFULL from registered occupancy only; a pop in the same cycle does not admit a write made while oFULL=1.
REQ-015 SHALL use a state machine IDLE, START, DATA, STOP.
REQ-016 IDLE: oUART_TX=1; if FIFO non-empty, pop head into an 8-bit shift register, clear bit index, reload baud counter, go to START.
REQ-017 START: oUART_TX=0 for CLKDIV cycles, then go to DATA.
REQ-018 DATA: oUART_TX=shift[0]; every CLKDIV cycles shift right and increment 3-bit index; after bit 7 go to STOP.
REQ-019 STOP: oUART_TX=1 for CLKDIV cycles, then go to IDLE.
REQ-020 SHALL spend exactly one cycle in IDLE (line high) between back-to-back frames; inter-frame period 10*CLKDIV+1 cycles.
REQ-021 Latency: byte written into empty FIFO with FSM in IDLE at edge k SHALL be popped at edge k+1; oUART_TX falls after edge k+1.
REQ-022 Simultaneous push and pop SHALL leave oLEVEL unchanged and keep FIFO order; read/write pointers wrap modulo DEPTH.
REQ-023 oLEVEL SHALL increment on push-only, decrement on pop-only, never exceed DEPTH or underflow.
REQ-024 oBUSY SHALL be 1 whenever state!=IDLE or oLEVEL!=0; otherwise 0.
REQ-025 oUART_TX SHALL be driven from a register (glitch-free).

Reset
REQ-026 While iRST=1: state=IDLE, oUART_TX=1, oLEVEL=0, oFULL=0, oBUSY=0, pointers, baud counter, bit index and shift register cleared; iWR ignored.
REQ-027 Reset asserted mid-frame SHALL immediately (asynchronously) force oUART_TX=1 and discard the frame and all FIFO contents; no partial frame resumes after release.
REQ-028 First push accepted at first rising edge after iRST deasserts.

Verification (CLKDIV=4, DEPTH=4)
REQ-029 Single byte: write 0xA5 at edge k -> oUART_TX low after edge k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; oBUSY falls when back in IDLE with FIFO empty.
REQ-030 Back-to-back: write 0x00,0xFF,0x55 consecutive cycles -> three frames in order, start edges 41 cycles apart, one idle-high cycle between frames.
REQ-031 Overflow: with FSM idle, write 6 bytes consecutively -> first popped immediately, next 4 fill FIFO (oFULL=1, oLEVEL=4), 6th dropped; exactly 5 frames transmitted.
REQ-032 Simultaneous push/pop: FIFO at 4, write while IDLE pops head -> write dropped, oLEVEL 3 next cycle; FIFO at 2, write during pop -> oLEVEL stays 2.
REQ-033 Reset mid-frame: assert iRST during DATA bit 3 of 0x0F with 2 bytes queued -> oUART_TX=1 immediately, oLEVEL=0, oBUSY=0; after release no frame emitted until new write.
REQ-034 Bit timing: over a 0x55 frame, measure every oUART_TX transition interval = 4 cycles exactly; total frame 40 cycles.

Source files
------------

// File: rtl/uart_tx_rv32_if.sv
// uart_tx_rv32_if
//   Bundles the core-side write strobe/data and the transmitter status and
//   serial line of uart_tx_rv32.
//   master : driven by the core/bench (iWR, iWDATA), observes status and line
//   slave  : the transmitter (samples iWR/iWDATA, drives oFULL, oBUSY,
//            oLEVEL, oUART_TX)
interface uart_tx_rv32_if;
    logic       iWR;
    logic [7:0] iWDATA;
    logic       oFULL;
    logic       oBUSY;
    logic [4:0] oLEVEL;
    logic       oUART_TX;

    modport master (
        output iWR,
        output iWDATA,
        input  oFULL,
        input  oBUSY,
        input  oLEVEL,
        input  oUART_TX
    );

    modport slave (
        input  iWR,
        input  iWDATA,
        output oFULL,
        output oBUSY,
        output oLEVEL,
        output oUART_TX
    );
endinterface

// File: rtl/uart_tx_rv32.sv
// uart_tx_rv32
//   8N1 UART transmitter with a small write FIFO, fed by core stores.
//   Parameters:
//     CLKDIV : clock cycles per UART bit (2..65535)
//     DEPTH  : FIFO entries (power of two, 2..16)
//   Ports:
//     iCLK  : clock, all state updates on the rising edge
//     iRST  : asynchronous active-high reset
//     bus   : slave side of uart_tx_rv32_if
//             iWR/iWDATA  byte push strobe and data
//             oFULL       FIFO holds DEPTH entries
//             oBUSY       FIFO non-empty or frame in progress
//             oLEVEL      FIFO occupancy 0..DEPTH
//             oUART_TX    registered serial line, idle high
//
//   state | meaning
//   IDLE  | line high; pops the FIFO head when one is available
//   START | start bit (line low) for CLKDIV cycles
//   DATA  | 8 data bits, LSB first, CLKDIV cycles each
//   STOP  | stop bit (line high) for CLKDIV cycles
module uart_tx_rv32 #(
    parameter int CLKDIV = 434,
    parameter int DEPTH  = 4
) (
    input  logic           iCLK,
    input  logic           iRST,
    uart_tx_rv32_if.slave  bus
);

    localparam int          PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKDIV - 1);
    localparam logic [4:0]  LEVEL_FULL  = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    level;
    logic [15:0]   baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx, tx_next;
    logic          full, push, pop, bit_end;

    // Full comes from the registered level only, so a pop in the same cycle
    // never makes room for a write presented while full.
    assign full    = (level == LEVEL_FULL);
    assign push    = bus.iWR && !full;
    assign pop     = (state == IDLE) && (level != 5'd0);
    assign bit_end = (baud_cnt == 16'd0);

    // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 5'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind valid pointers.
    always_ff @(posedge iCLK) begin
        if (push && !iRST)
            mem[wr_ptr] <= bus.iWDATA;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = 1'b1;

        case (state)
            IDLE: begin
                if (pop) begin
                    shift_next = mem[rd_ptr];
                    bit_next   = 3'd0;
                    baud_next  = BAUD_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = BAUD_RELOAD;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        shift_next = {1'b0, shift[7:1]};
                        bit_next   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (bit_end)
                    state_next = IDLE;
                else
                    baud_next = baud_cnt - 16'd1;
            end
            default: state_next = IDLE;
        endcase

        // Line value is derived from the next state so the register holds
        // the bit for exactly the cycles spent in that state.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign bus.oUART_TX = tx;
    assign bus.oFULL    = full;
    assign bus.oLEVEL   = level;
    assign bus.oBUSY    = (state != IDLE) || (level != 5'd0);

endmodule
